// File: rtl/ttl_busseq_pkg.sv
// Shared definitions for the tri-state bus transfer sequencer: FSM encoding,
// counter width and a helper that extracts one destination index from a packed vector.
package ttl_busseq_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Wide enough for SETTLE and TURNAROUND values up to 7.
    localparam int CNT_W = 3;

    function automatic logic [7:0] dst_slice(input logic [63:0] vec, input int idx, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return 8'((vec >> (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/ttl_rr_arbiter.sv
// Combinational requester arbiter: round-robin from ptr, or fixed lowest-index
// priority when BUSSEQ_FIXED_PRIO_EN is defined (ptr is then ignored).
module ttl_rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int IW    = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    win,
    output logic             valid
);

`ifdef BUSSEQ_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!valid && req[IW'(k)]) begin
                valid = 1'b1;
                win   = IW'(k);
            end
        end
    end
`else
    // Search upward from ptr with wrap; the first set bit wins.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!valid && req[IW'(idx)]) begin
                valid = 1'b1;
                win   = IW'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/ttl_bus_xfer_seq.sv
// Sequences register-to-register moves over a shared 74574-style tri-state bus:
// drive OE_bar, pulse the destination LD, then release. Macro: BUSSEQ_FIXED_PRIO_EN.
module ttl_bus_xfer_seq
    import ttl_busseq_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int N_DST      = 4,
    parameter int DST_W      = 2,
    parameter int SETTLE     = 1,
    parameter int TURNAROUND = 1
) (
    input  logic                   CLK,
    input  logic                   RST_bar,
    input  logic [N_SRC-1:0]       REQ,
    input  logic [N_SRC*DST_W-1:0] DST,
    output logic [N_SRC-1:0]       OE_bar,
    output logic [N_DST-1:0]       LD,
    output logic [N_SRC-1:0]       GNT,
    output logic                   ERR,
    output logic                   BUSY
);

    localparam int IW = $clog2(N_SRC);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    win;
    logic             valid;
    logic [IW-1:0]    win_q;
    logic [DST_W-1:0] dst_q;
    logic [N_DST-1:0] ld_dec;
    logic             dst_bad;

    ttl_rr_arbiter #(.N_SRC(N_SRC), .IW(IW)) u_arb (
        .req   (REQ),
        .ptr   (ptr),
        .win   (win),
        .valid (valid)
    );

    always_comb begin
        ld_dec = '0;
        for (int i = 0; i < N_DST; i++) ld_dec[i] = (dst_q == DST_W'(i));
    end

    assign dst_bad = {1'b0, dst_q} >= (DST_W+1)'(N_DST);

`ifdef BUSSEQ_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge CLK) begin
        if (!RST_bar)
            ptr <= '0;
        else if (state == ST_IDLE && valid)
            ptr <= (int'(win) == N_SRC - 1) ? '0 : win + 1'b1;
    end
`endif

    // Outputs are registered, so each transition loads the values for the state it enters.
    always_ff @(posedge CLK) begin
        if (!RST_bar) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            win_q  <= '0;
            dst_q  <= '0;
            OE_bar <= '1;
            LD     <= '0;
            GNT    <= '0;
            ERR    <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            LD  <= '0;
            GNT <= '0;
            ERR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        win_q  <= win;
                        dst_q  <= DST_W'(dst_slice(64'(DST), int'(win), DST_W));
                        OE_bar <= ~(N_SRC'(1) << win);
                        cnt    <= CNT_W'(SETTLE - 1);
                        BUSY   <= 1'b1;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == '0) begin
                        LD    <= ld_dec;
                        ERR   <= dst_bad;
                        GNT   <= N_SRC'(1) << win_q;
                        state <= ST_LATCH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_LATCH: begin
                    OE_bar <= '1;
                    if (TURNAROUND == 0) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt   <= CNT_W'(TURNAROUND - 1);
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == '0) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    OE_bar <= '1;
                    BUSY   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ttl_bus_xfer_seq.md
Name: ttl_bus_xfer_seq

Overview:
- Sequences register-to-register transfers over one shared tri-state bus built from ttl_74574-style octal registers.
- Arbitrates between N_SRC requesters; requester i owns source register i.
- Per transfer: drives that register's active-low output enable, then pulses the destination register's rising-edge clock, then releases the bus with a break-before-make gap.
- Sits between the microcode/control layer and the register file.

Parameters:
- N_SRC, 4, number of requesters / source registers (OE_bar lines), 2..8
- N_DST, 4, number of destination registers (LD lines), 2..8
- DST_W, 2, width of one destination index; must satisfy 2**DST_W >= N_DST
- SETTLE, 1, cycles OE_bar is low before LD rises; minimum 1
- TURNAROUND, 1, dead cycles with all OE_bar high after a transfer; 0..7

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST_bar  in  1  reset, synchronous, active-low
- REQ  in  N_SRC  bit i = requester i asks to move source reg i to its DST
- DST  in  N_SRC*DST_W  packed destination index; slice i belongs to requester i
- OE_bar  out  N_SRC  active-low output enables to source registers; at most one low
- LD  out  N_DST  one-cycle high pulse, wired to destination register CLK
- GNT  out  N_SRC  one-cycle completion pulse to the winning requester
- ERR  out  1  one-cycle pulse: granted DST index >= N_DST
- BUSY  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset (RST_bar low at an edge):
  - OE_bar all 1, LD 0, GNT 0, ERR 0, BUSY 0
  - state IDLE, round-robin pointer 0
  - Overrides any state; a transfer in progress is abandoned. Because OE_bar goes high on that same edge, the bus floats.
- FSM: IDLE -> DRIVE -> LATCH -> RELEASE -> IDLE.
- IDLE:
  - REQ and DST are sampled only here.
  - If any REQ bit is set: pick a winner round-robin, starting at the pointer and searching upward with wrap.
  - Latch the winner's index and its DST slice. Set pointer = winner+1 (mod N_SRC).
  - Next state DRIVE, with OE_bar[winner]=0 and BUSY=1.
- DRIVE: hold OE_bar low for SETTLE cycles (counter), then go to LATCH.
- LATCH: one cycle.
  - OE_bar stays low.
  - If the latched DST < N_DST: LD[DST]=1. Otherwise LD stays 0 and ERR=1.
  - GNT[winner]=1 in the same cycle.
- RELEASE:
  - All OE_bar high.
  - Stay TURNAROUND cycles, then go to IDLE.
  - If TURNAROUND=0, LATCH goes directly to IDLE.
- Transfer period is SETTLE+TURNAROUND+2 cycles (default 4). First OE_bar low occurs one cycle after REQ is sampled in IDLE.
- Once arbitrated, a transfer is committed. REQ or DST changes after that are ignored until IDLE.
- A REQ bit still high in IDLE after its GNT counts as a new request.
- OE_bar never has two bits low at once. The transition from one source's OE_bar low to another's always passes through at least one cycle (IDLE) with all OE_bar high.
- No requests: stays IDLE; pointer unchanged.

Optional Feature:
- Macro BUSSEQ_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority; lowest REQ index wins; no pointer register.
- Undefined: round-robin as above.
- All other timing is identical in both cases.

Decomposition:
- Package ttl_busseq_pkg holds:
  - state encoding (IDLE, DRIVE, LATCH, RELEASE)
  - counter width constant (3 bits, covers SETTLE/TURNAROUND up to 7)
  - function extracting a DST_W slice from a packed vector
- One sub-module, ttl_rr_arbiter:
  - inputs REQ and pointer; outputs winner index and valid; combinational
  - implements the BUSSEQ_FIXED_PRIO_EN switch internally

Test Plan:
- Reset mid-transfer: RST_bar low during LATCH -> next edge OE_bar=4'b1111, LD=0, GNT=0, BUSY=0. After release, REQ=4'b0001 restarts at pointer 0.
- Single transfer, REQ=4'b0100, DST slice2=3, defaults:
  - edge0 sample -> OE_bar=4'b1011 for 2 cycles
  - LD=4'b1000 and GNT=4'b0100 in the 2nd cycle
  - then 1 cycle all OE_bar high, then IDLE
- Round-robin, REQ=4'b1111 held:
  - GNT order 0,1,2,3,0, one every 4 cycles
  - OE_bar never has >1 zero; at least 1 all-high cycle between drivers
- Same stimulus with BUSSEQ_FIXED_PRIO_EN: GNT always bit 0.
- Bad destination, N_DST=3, DST=3: ERR pulses in the LATCH cycle, LD stays 0, GNT still issued.
- Timing parameters: SETTLE=3, TURNAROUND=0 -> OE_bar low 4 cycles, LD in the 4th, back-to-back period 5 cycles. REQ dropped during DRIVE -> transfer still completes.
